// File: rtl/fifo_stream_reader_if.sv
// Stream-side bundle for fifo_stream_reader: FIFO read port plus the
// valid/ready output stream. The master modport is the reader itself; the
// slave modport is the environment (FIFO and downstream consumer).
interface fifo_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty;
    logic             fifo_dequeue;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             idle;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_dequeue, m_valid, m_data, m_last, idle
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_dequeue, m_valid, m_data, m_last, idle
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO. Issues dequeues, absorbs the
// FIFO's one-cycle registered read latency in a 2-entry skid buffer and
// presents the words as a valid/ready stream with full back-pressure.
// Optional feature macro: FIFO_READER_LAST_EN enables m_last generation
// every BURST_LEN beats; without it m_last is tied to 0.
module fifo_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_stream_reader_if.master  bus
);

    // Elaboration-time guard on the burst length range.
    if (BURST_LEN < 2 || BURST_LEN > 65535) begin : g_bad_burst_len
        $error("fifo_stream_reader: BURST_LEN must be in 2..65535");
    end

    logic [WIDTH-1:0] buf_q [2];
    logic             rd_idx_q, rd_idx_d;
    logic             wr_idx_q, wr_idx_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_flight_q;
    logic             pop;
    logic             dequeue;
    logic [2:0]       pending;

    // Pop/issue decisions and next buffer bookkeeping.
    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        pop      = (occ_q != 2'd0) && bus.m_ready;
        // Words owned by the reader after this edge: buffered + arriving - leaving.
        pending  = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
        // Keep at most two words owned; never dequeue from an empty FIFO or in reset.
        dequeue  = rst_n && !bus.fifo_empty && (pending <= 3'd1);
        occ_d    = pending[1:0];
        rd_idx_d = rd_idx_q ^ pop;
        wr_idx_d = wr_idx_q ^ in_flight_q;
    end

    // Control state: occupancy, indices and the read-in-flight flag.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= 2'd0;
            rd_idx_q    <= 1'b0;
            wr_idx_q    <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            in_flight_q <= dequeue;
        end
    end

    // Skid buffer storage: the word requested last cycle lands at the tail.
    // NOTE: the two entries are reset because m_data must read back 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else if (in_flight_q) begin
            buf_q[wr_idx_q] <= bus.fifo_data;
        end
    end

    assign bus.fifo_dequeue = dequeue;
    assign bus.m_valid      = (occ_q != 2'd0);
    assign bus.m_data       = buf_q[rd_idx_q];
    assign bus.idle         = (occ_q == 2'd0) && !in_flight_q;

`ifdef FIFO_READER_LAST_EN
    localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

    logic [15:0] beat_q, beat_d;

    // Beat counter advances on each accepted word and wraps at the burst end.
    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
        end
    end

    // Beat counter register; only moves on a pop, so m_last holds through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= 16'd0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign bus.m_last = (occ_q != 2'd0) && (beat_q == LAST_BEAT);
`else
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A queue models the FIFO with
// its one-cycle registered read; the reference tracks words issued and
// accepted and derives the expected stream from those counts.
module tb_fifo_stream_reader;

    localparam int W  = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.WIDTH(W)) bus ();

    fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] fifo_q [$];
    logic [31:0] sent   [$];
    int          issued_prev;
    int          pops_prev;
    bit          deq_last;
    int          cyc;
    int          pop_cycles [$];

    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    logic        s_deq, s_valid, s_last, s_idle;
    logic [31:0] s_data;
    bit          s_pop;

    typedef struct {
        bit          push;
        logic [31:0] w;
        bit          rdy;
        bit          e_deq;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_idle;
    } vec_t;

    vec_t lat_tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_last_for(input int beat);
`ifdef FIFO_READER_LAST_EN
        return (beat % BL) == (BL - 1);
`else
        return (beat < 0);
`endif
    endfunction

    // Compare DUT outputs against the count-based reference (called mid-cycle).
    task automatic model_check();
        int outstanding;
        int buffered;
        bit exp_valid;
        bit exp_pop;
        bit exp_deq;
        outstanding = issued_prev - pops_prev;
        buffered    = outstanding - int'(deq_last);
        exp_valid   = buffered > 0;
        exp_pop     = exp_valid && bus.m_ready;
        exp_deq     = !bus.fifo_empty && ((outstanding - int'(exp_pop)) <= 1);

        s_deq   = bus.fifo_dequeue;
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_last  = bus.m_last;
        s_idle  = bus.idle;
        s_pop   = s_valid && bus.m_ready;

        check("m_valid", 32'(s_valid), 32'(exp_valid));
        check("idle", 32'(s_idle), 32'(outstanding == 0));
        check("fifo_dequeue", 32'(s_deq), 32'(exp_deq));
        if (exp_valid) begin
            if (pops_prev < sent.size()) begin
                check("m_data", s_data, sent[pops_prev]);
            end else begin
                check("m_data_beyond_sent", 32'(pops_prev), 32'(sent.size()));
            end
            check("m_last", 32'(s_last), 32'(exp_last_for(pops_prev)));
        end
        if (prev_stall) begin
            check("stall_valid", 32'(s_valid), 32'd1);
            check("stall_data", s_data, prev_data);
            check("stall_last", 32'(s_last), 32'(prev_last));
        end
        prev_stall = s_valid && !bus.m_ready;
        prev_data  = s_data;
        prev_last  = s_last;
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic cycle(input bit do_push, input logic [31:0] w, input bit rdy);
        if (do_push) begin
            fifo_q.push_back(w);
            sent.push_back(w);
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.m_ready    = rdy;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        if (s_deq && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
        issued_prev += int'(s_deq);
        pops_prev   += int'(s_pop);
        if (s_pop) pop_cycles.push_back(cyc);
        deq_last = s_deq;
        cyc++;
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic preload(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 32'(i));
            sent.push_back(base + 32'(i));
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic model_reset();
        fifo_q.delete();
        sent.delete();
        pop_cycles.delete();
        issued_prev = 0;
        pops_prev   = 0;
        deq_last    = 1'b0;
        prev_stall  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        check({tag, "_m_data"}, bus.m_data, 32'd0);
        check({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
        check({tag, "_idle"}, 32'(bus.idle), 32'd1);
        check({tag, "_fifo_dequeue"}, 32'(bus.fifo_dequeue), 32'd0);
    endtask

    initial begin
        int base_pops;
        int base_iss;
        int lasts;
        int budget;
        int pat [6];

        pat = '{1, 0, 0, 1, 1, 0};
        cyc = 0;
        rst_n = 1'b0;
        bus.m_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency: one word into an empty FIFO, consumer always ready.
        lat_tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1};
        lat_tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        lat_tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0};
        lat_tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        lat_tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cycle(lat_tbl[i].push, lat_tbl[i].w, lat_tbl[i].rdy);
            check($sformatf("lat%0d_deq", i), 32'(s_deq), 32'(lat_tbl[i].e_deq));
            check($sformatf("lat%0d_valid", i), 32'(s_valid), 32'(lat_tbl[i].e_valid));
            check($sformatf("lat%0d_idle", i), 32'(s_idle), 32'(lat_tbl[i].e_idle));
            if (lat_tbl[i].e_valid) check($sformatf("lat%0d_data", i), s_data, lat_tbl[i].e_data);
        end

        // Streaming: 16 preloaded words, no bubbles after the first beat.
        preload(16, 32'd0);
        pop_cycles.delete();
        base_pops = pops_prev;
        budget = 0;
        while (pops_prev - base_pops < 16 && budget < 60) begin
            cycle(1'b0, 32'h0, 1'b1);
            budget++;
        end
        check("stream_count", 32'(pops_prev - base_pops), 32'd16);
        if (pop_cycles.size() == 16) check("stream_no_bubbles", 32'(pop_cycles[15] - pop_cycles[0]), 32'd15);
        else check("stream_pop_record", 32'(pop_cycles.size()), 32'd16);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Back-pressure: ready pattern 1,0,0,1,1,0 repeating.
        preload(16, 32'd0);
        base_pops = pops_prev;
        budget = 0;
        while (pops_prev - base_pops < 16 && budget < 200) begin
            cycle(1'b0, 32'h0, pat[budget % 6] != 0);
            budget++;
        end
        check("bp_count", 32'(pops_prev - base_pops), 32'd16);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Empty boundary: exactly three dequeues and three beats.
        preload(3, 32'hC0DE_0000);
        base_pops = pops_prev;
        base_iss  = issued_prev;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
        check("empty_deqs", 32'(issued_prev - base_iss), 32'd3);
        check("empty_beats", 32'(pops_prev - base_pops), 32'd3);

        // Reset mid-operation with two words held and more waiting in the FIFO.
        preload(4, 32'hBEEF_0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
        check("pre_reset_held", 32'(issued_prev - pops_prev), 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            check("post_rst_data", s_data, 32'd0);
            check("post_rst_last", 32'(s_last), 32'd0);
        end

        // Bursts: 10 words, random ready; beat count restarted by the reset.
        lasts = 0;
        for (int i = 0; i < 10; i++) begin
            fifo_q.push_back(32'h1000 + 32'(i));
            sent.push_back(32'h1000 + 32'(i));
        end
        budget = 0;
        while (pops_prev < 10 && budget < 200) begin
            cycle(1'b0, 32'h0, $urandom_range(0, 1) != 0);
            if (s_pop && s_last) lasts++;
            budget++;
        end
        check("burst_count", 32'(pops_prev), 32'd10);
`ifdef FIFO_READER_LAST_EN
        check("burst_lasts", 32'(lasts), 32'd2);
`else
        check("burst_lasts", 32'(lasts), 32'd0);
`endif

        // Random traffic against the reference, then drain.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3) != 0);
        end
        budget = 0;
        while ((pops_prev < sent.size() || issued_prev != pops_prev) && budget < 2000) begin
            cycle(1'b0, 32'h0, 1'b1);
            budget++;
        end
        check("random_drained", 32'(pops_prev), 32'(sent.size()));
        cycle(1'b0, 32'h0, 1'b1);
        check("final_idle", 32'(s_idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's synchronous FIFO: drives the FIFO's dequeue strobe, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream with full back-pressure. It sits between a FIFO's output port and any downstream stream consumer. It sustains one word per cycle and never drops or duplicates a word.

## Interface
- WIDTH, 32, data word width; must match the attached FIFO.
- BURST_LEN, 8, beats per burst for m_last generation; legal range 2..65535. Used only with FIFO_READER_LAST_EN.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dequeue  output  1  dequeue strobe to the FIFO; combinational.
- fifo_data  input  WIDTH  FIFO data_out; valid the cycle after an accepted dequeue.
- m_valid  output  1  stream word valid; registered.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH  stream word; registered.
- m_last  output  1  final beat of a burst; registered. Constant 0 without FIFO_READER_LAST_EN.
- idle  output  1  high when no word is held and no read is in flight.

## Operation
- State:
  - 2-entry skid buffer (entries, rd/wr index, occ 0..2).
  - in_flight flag: a dequeue was issued last cycle.
- m_data and m_valid reflect the buffer head. m_valid = (occ != 0).
- Pop: m_valid && m_ready. The head advances.
- Issue rule: fifo_dequeue = !fifo_empty && (occ + in_flight - pop) <= 1.
  - The buffer therefore never overflows.
  - fifo_dequeue is never asserted while fifo_empty = 1.
- Capture: when in_flight = 1, fifo_data is written to the buffer tail on that edge, unconditionally.
- in_flight next value = fifo_dequeue.
- Simultaneous capture and pop in the same cycle: occ is unchanged and ordering is preserved.
- Words leave in exact FIFO order.
- While m_valid = 1 and m_ready = 0, m_data and m_last are held stable.
- idle = (occ == 0) && !in_flight.

## Timing
- Reset (async, rst_n = 0):
  - occ = 0, in_flight = 0, indices = 0, burst count = 0.
  - m_valid = 0, m_data = 0, m_last = 0, idle = 1, fifo_dequeue = 0.
- Reset mid-operation: any in-flight or buffered word is discarded. The FIFO's own reset is expected to run concurrently.
- Latency:
  - FIFO goes non-empty in cycle N with the reader idle.
  - fifo_dequeue is high in cycle N.
  - fifo_data is valid in N+1.
  - m_valid rises in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, there is one pop per cycle. Steady state is occ = 1, in_flight = 1.
- Back-pressure: with m_ready = 0, the reader stops issuing once occ + in_flight = 2. At most 2 words are held.
- FIFO drains mid-stream: dequeue stops the same cycle fifo_empty rises. Buffered words still drain to the consumer.

## Configuration
- FIFO_READER_LAST_EN, defined:
  - A 16-bit beat counter increments on each pop and wraps from BURST_LEN-1 to 0.
  - m_last = 1 on the beat where the counter equals BURST_LEN-1, and is travelled with the head word.
  - The counter resets to 0 asynchronously.
- FIFO_READER_LAST_EN, undefined: no counter logic; m_last tied to 0.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle with occ = 2 -> immediately m_valid = 0, m_data = 0, idle = 1, fifo_dequeue = 0. After release with the FIFO empty, all outputs stay at reset values.
- Latency: push 0xA5A5_0001 into an empty FIFO with m_ready = 1 -> fifo_dequeue high one cycle; m_valid high exactly 2 cycles later with m_data = 0xA5A5_0001 for one cycle; idle returns to 1.
- Streaming: preload 16 words 0..15, hold m_ready = 1 -> 16 consecutive m_valid beats carrying 0..15 in order, no bubbles after the first.
- Back-pressure: preload 0..15, toggle m_ready in pattern 1,0,0,1,1,0 repeating -> all 16 words delivered in order; m_data stable during every stall; fifo_dequeue never high while occ + in_flight = 2 without a pop.
- Empty boundary: preload 3 words, m_ready = 1 -> exactly 3 dequeues, 3 beats, fifo_dequeue never asserted while fifo_empty = 1.
- Bursts (FIFO_READER_LAST_EN, BURST_LEN = 4): stream 10 words with random m_ready -> m_last = 1 on beats 3 and 7 only, held through stalls; without the macro, m_last = 0 throughout.
